prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
- REQ-001: Psize, default 5, program memory address width in bits.
- REQ-002: Isize, default 16, instruction width in bits; SHALL be a multiple of 8, with B = Isize/8 bytes per word.
- REQ-003: clk  input  1  single clock; all state changes on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- REQ-006: len  input  Psize+1  number of words to load, latched on an accepted start; legal range 0..2^Psize.
- REQ-007: rx_data  input  8  incoming byte.
- REQ-008: rx_valid  input  1  rx_data is valid this cycle.
- REQ-009: rx_ready  output  1  loader can accept a byte this cycle.
- REQ-010: we  output  1  program memory write enable, one-cycle pulse per word.
- REQ-011: waddr  output  Psize  program memory write address.
- REQ-012: wdata  output  Isize  program memory write data.
- REQ-013: busy  output  1  a load is in progress (RECV or WRITE).
- REQ-014: done  output  1  the last load completed; held until the next start or reset.
- REQ-015: cpu_hold  output  1  holds the processor in reset while high; high from reset until the first done.
- REQ-016: csum  output  8  XOR of all bytes accepted in the current or last load.

Function
- REQ-017: The FSM SHALL have exactly four states: IDLE, RECV, WRITE, DONE.
- REQ-018: An accepted start SHALL:
  - latch len;
  - clear the word counter, byte counter and csum;
  - go to RECV if len>0, otherwise go directly to DONE.
- REQ-019: A byte SHALL be accepted only in a cycle where rx_valid && rx_ready; rx_ready=1 only in RECV.
- REQ-020: Bytes SHALL be assembled most-significant first: the first accepted byte of a word fills wdata[Isize-1:Isize-8].
- REQ-021: On acceptance of the B-th byte of a word, the next state SHALL be WRITE; the byte counter wraps to 0.
- REQ-022: In WRITE, for exactly one cycle, we=1, waddr = word counter, and wdata = assembled word; we=0 in all other states.
- REQ-023: After WRITE, the word counter SHALL increment:
  - if the incremented count equals the latched len, go to DONE;
  - otherwise return to RECV.
- REQ-024: The write address SHALL be the low Psize bits of the word counter; the counter is Psize+1 bits, so len=2^Psize writes addresses 0..2^Psize-1 with no wrap.
- REQ-025: Minimum throughput SHALL be B+1 cycles per word (B accept cycles, then one WRITE cycle).
- REQ-026: rx_valid gaps in RECV SHALL stall assembly without loss; partially assembled bytes are retained.
- REQ-027: csum SHALL update to csum ^ rx_data in the cycle after each accepted byte.
- REQ-028: busy = (state==RECV || state==WRITE).
- REQ-029: done = (state==DONE).
- REQ-030: cpu_hold SHALL:
  - be set by reset;
  - clear on the first entry to DONE;
  - set again on any later accepted start, clearing again on the following DONE entry.
- REQ-031: start asserted in RECV or WRITE SHALL be ignored, with no effect on counters or csum.
- REQ-032: start in DONE SHALL behave exactly as in IDLE.
- REQ-033: len > 2^Psize SHALL be treated as 2^Psize (saturated at latch).
- REQ-034: All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs, rx_ready included.

Reset
- REQ-035: Reset SHALL take priority over all other inputs in the same cycle.
- REQ-036: After reset: state=IDLE, rx_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, cpu_hold=1, csum=0, all counters 0.
- REQ-037: Reset asserted mid-load SHALL:
  - abandon the load immediately;
  - prevent any further we pulses;
  - leave memory contents already written undefined from the loader's point of view.

Verification
- REQ-038: Psize=5, Isize=16; start with len=2; bytes 12 34 AB CD sent back-to-back → we pulses at waddr 0 (wdata 1234) and waddr 1 (wdata ABCD); done=1 and cpu_hold=0 on the cycle after the second WRITE; csum=0x40.
- REQ-039: start with len=0 → next cycle done=1, busy=0, no we pulse, rx_ready never asserted.
- REQ-040: len=32 with a 64-byte stream → 32 writes to addresses 0..31 in order, no write to address 0 after the first; done asserted; len=40 behaves identically to len=32.
- REQ-041: rx_valid toggled 1/0 every cycle during a len=1 load of 5A A5 → single write with wdata 5AA5, issued one cycle after the second accepted byte.
- REQ-042: start pulsed while busy, then reset asserted after the first byte of word 1 → start has no effect; after reset, no we pulse, cpu_hold=1, all outputs at reset values.
- REQ-043: Load len=1 (00 01), then a second start with len=1 (FF FF) → cpu_hold rises on the second start and falls at its DONE; csum=0x00; second write at waddr 0 with wdata FFFF.

Source files
------------

// File: rtl/prog_loader_if.sv
// prog_loader_if: incoming byte stream and program-memory write port of the loader
interface prog_loader_if #(
    parameter int Psize = 5,
    parameter int Isize = 16
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             we;
    logic [Psize-1:0] waddr;
    logic [Isize-1:0] wdata;
    modport master (input rx_data, rx_valid, output rx_ready, we, waddr, wdata);
    modport slave (output rx_data, rx_valid, input rx_ready, we, waddr, wdata);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: assembles MSB-first bytes into words, writes them to program memory, holds the CPU until done
module prog_loader #(
    parameter int Psize = 5,
    parameter int Isize = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [Psize:0] len,
    prog_loader_if.master  bus,
    output logic           busy,
    output logic           done,
    output logic           cpu_hold,
    output logic [7:0]     csum
);
    localparam int B = Isize / 8;
    localparam int BW = B > 1 ? $clog2(B) : 1;
    localparam logic [Psize:0] LMAX = (Psize+1)'(1) << Psize;
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;
    state_e           state_q, state_d;
    logic [Psize:0]   len_q, len_d, wcnt_q, wcnt_d, len_sat;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [Isize-1:0] word_q, word_d;
    logic [7:0]       csum_q, csum_d;
    logic             hold_q, hold_d;
    logic             go, take, last_byte;

    assign len_sat = len > LMAX ? LMAX : len;
    assign go = start && (state_q == IDLE || state_q == DONE);
    assign take = bus.rx_valid && state_q == RECV;
    assign last_byte = bcnt_q == BW'(B - 1);

    always_comb begin
        state_d = state_q;
        len_d = len_q;
        wcnt_d = wcnt_q;
        bcnt_d = bcnt_q;
        word_d = word_q;
        csum_d = csum_q;
        hold_d = hold_q;
        if (go) begin
            len_d = len_sat;
            wcnt_d = '0;
            bcnt_d = '0;
            csum_d = '0;
            hold_d = len_sat != '0;
            state_d = len_sat == '0 ? DONE : RECV;
        end
        if (take) begin
            word_d = (word_q << 8) | Isize'(bus.rx_data);
            csum_d = csum_q ^ bus.rx_data;
            bcnt_d = last_byte ? '0 : bcnt_q + BW'(1);
            state_d = last_byte ? WRITE : RECV;
        end
        if (state_q == WRITE) begin
            wcnt_d = wcnt_q + (Psize+1)'(1);
            state_d = wcnt_d == len_q ? DONE : RECV;
            hold_d = hold_q && wcnt_d != len_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q <= '0;
            wcnt_q <= '0;
            bcnt_q <= '0;
            word_q <= '0;
            csum_q <= '0;
            hold_q <= 1'b1;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            wcnt_q <= wcnt_d;
            bcnt_q <= bcnt_d;
            word_q <= word_d;
            csum_q <= csum_d;
            hold_q <= hold_d;
        end
    end

    assign bus.rx_ready = state_q == RECV;
    assign bus.we = state_q == WRITE;
    assign bus.waddr = wcnt_q[Psize-1:0];
    assign bus.wdata = word_q;
    assign busy = state_q == RECV || state_q == WRITE;
    assign done = state_q == DONE;
    assign cpu_hold = hold_q;
    assign csum = csum_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scenario tasks with a write scoreboard checked on every we pulse
module tb_prog_loader;
    logic       clk, reset, start, busy, done, cpu_hold;
    logic [5:0] len_in;
    logic [7:0] csum;
    int         checks = 0, errors = 0;
    logic [20:0] sb[$];
    logic [20:0] exp_w;

    prog_loader_if #(.Psize(5), .Isize(16)) bus ();

    prog_loader #(.Psize(5), .Isize(16)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len_in), .bus(bus),
        .busy(busy), .done(done), .cpu_hold(cpu_hold), .csum(csum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we: waddr=%0d wdata=%h, required no write", bus.waddr, bus.wdata);
            end else begin
                exp_w = sb.pop_front();
                if ({bus.waddr, bus.wdata} !== exp_w) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             bus.waddr, bus.wdata, exp_w[20:16], exp_w[15:0]);
                end
            end
        end
    end

    task automatic do_start(input logic [5:0] l);
        start = 1'b1;
        len_in = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got rx_ready=%b, expected 1 within 50 cycles", bus.rx_ready);
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got done=%b, expected 1 within 200 cycles", done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.rx_ready, bus.we, busy, done, cpu_hold} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 00001", {bus.rx_ready, bus.we, busy, done, cpu_hold});
        end
        checks++;
        if ({bus.waddr, bus.wdata, csum} !== 29'd0) begin
            errors++;
            $display("FAIL reset_values: got waddr=%0d wdata=%h csum=%h, expected 0", bus.waddr, bus.wdata, csum);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        sb.push_back({5'd0, 16'h1234});
        sb.push_back({5'd1, 16'hABCD});
        do_start(6'd2);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        checks++;
        if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd1, 16'hABCD}) begin
            errors++;
            $display("FAIL basic_write_timing: got we=%b addr=%0d data=%h, expected 1/1/abcd", bus.we, bus.waddr, bus.wdata);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, cpu_hold, busy} !== 3'b100) begin
            errors++;
            $display("FAIL basic_done: got done,cpu_hold,busy=%b, expected 100", {done, cpu_hold, busy});
        end
        checks++;
        if (csum !== 8'h40) begin
            errors++;
            $display("FAIL basic_csum: got %h, expected 40", csum);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL basic_writes: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_len_zero();
        logic seen = 1'b0;
        do_start(6'd0);
        checks++;
        if ({done, busy, bus.rx_ready, bus.we} !== 4'b1000) begin
            errors++;
            $display("FAIL len0_state: got done,busy,rx_ready,we=%b, expected 1000", {done, busy, bus.rx_ready, bus.we});
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | bus.rx_ready | bus.we;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL len0_quiet: got rx_ready/we seen=%b, expected 0", seen);
        end
    endtask

    task automatic test_full(input logic [5:0] l);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 32; i++) sb.push_back({5'(i), 8'(i * 3 + 1), 8'(i * 7 + 2)});
        do_start(l);
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i * 3 + 1));
            send_byte(8'(i * 7 + 2));
            x = x ^ 8'(i * 3 + 1) ^ 8'(i * 7 + 2);
        end
        wait_done();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL full_writes_len%0d: got %0d pending, expected 0", l, sb.size());
        end
        checks++;
        if (csum !== x) begin
            errors++;
            $display("FAIL full_csum_len%0d: got %h, expected %h", l, csum, x);
        end
        checks++;
        if ({busy, bus.rx_ready} !== 2'b00) begin
            errors++;
            $display("FAIL full_idle_len%0d: got busy,rx_ready=%b, expected 00", l, {busy, bus.rx_ready});
        end
    endtask

    task automatic test_gaps();
        sb.push_back({5'd0, 16'h5AA5});
        do_start(6'd1);
        bus.rx_data = 8'h5A;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        checks++;
        if ({bus.rx_ready, bus.we} !== 2'b10) begin
            errors++;
            $display("FAIL gap_stall: got rx_ready,we=%b, expected 10", {bus.rx_ready, bus.we});
        end
        @(posedge clk); #1;
        bus.rx_data = 8'hA5;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        checks++;
        if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd0, 16'h5AA5}) begin
            errors++;
            $display("FAIL gap_write: got we=%b addr=%0d data=%h, expected 1/0/5aa5", bus.we, bus.waddr, bus.wdata);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, csum} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL gap_done: got done=%b csum=%h, expected 1/ff", done, csum);
        end
    endtask

    task automatic test_busy_reset();
        sb.push_back({5'd0, 16'h1122});
        do_start(6'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        start = 1'b1;
        len_in = 6'd0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, done, bus.waddr} !== {2'b10, 5'd1}) begin
            errors++;
            $display("FAIL start_in_write: got busy=%b done=%b waddr=%0d, expected 1/0/1", busy, done, bus.waddr);
        end
        start = 1'b1;
        len_in = 6'd1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, csum} !== {1'b1, 8'h33}) begin
            errors++;
            $display("FAIL start_in_recv: got busy=%b csum=%h, expected 1/33", busy, csum);
        end
        send_byte(8'h44);
        checks++;
        if (csum !== 8'h77) begin
            errors++;
            $display("FAIL partial_csum: got %h, expected 77", csum);
        end
        reset = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h55;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({bus.rx_ready, bus.we, busy, done, cpu_hold, bus.waddr, bus.wdata, csum} !== {5'b00001, 29'd0}) begin
            errors++;
            $display("FAIL midload_reset: got flags=%b waddr=%0d wdata=%h csum=%h, expected 00001/0/0/0",
                     {bus.rx_ready, bus.we, busy, done, cpu_hold}, bus.waddr, bus.wdata, csum);
        end
        repeat (6) @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        checks++;
        if ({bus.rx_ready, busy, done, cpu_hold} !== 4'b0001 || sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset_idle: got flags=%b pending=%0d, expected 0001/0",
                     {bus.rx_ready, busy, done, cpu_hold}, sb.size());
        end
    endtask

    task automatic test_reload();
        sb.push_back({5'd0, 16'h0001});
        do_start(6'd1);
        send_byte(8'h00);
        send_byte(8'h01);
        wait_done();
        checks++;
        if ({cpu_hold, csum} !== {1'b0, 8'h01}) begin
            errors++;
            $display("FAIL reload_first: got cpu_hold=%b csum=%h, expected 0/01", cpu_hold, csum);
        end
        sb.push_back({5'd0, 16'hFFFF});
        do_start(6'd1);
        checks++;
        if ({cpu_hold, busy, csum} !== {2'b11, 8'h00}) begin
            errors++;
            $display("FAIL reload_start: got cpu_hold=%b busy=%b csum=%h, expected 1/1/00", cpu_hold, busy, csum);
        end
        send_byte(8'hFF);
        send_byte(8'hFF);
        wait_done();
        checks++;
        if ({cpu_hold, csum} !== {1'b0, 8'h00} || sb.size() != 0) begin
            errors++;
            $display("FAIL reload_second: got cpu_hold=%b csum=%h pending=%0d, expected 0/00/0", cpu_hold, csum, sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        len_in = '0;
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;
        test_reset();
        test_basic();
        test_len_zero();
        test_full(6'd32);
        test_full(6'd40);
        test_gaps();
        test_busy_reset();
        test_reload();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_scoreboard: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
